sugar_event_queue: RTL and testbench

Downstream collector for the per-ant sugar events of the ant array. On each move strobe it latches every ant's `collecting_sugar`/`dropping_sugar` flag and coordinates, then serializes them through a FIFO. Collect events are retired as read-modify-write decrements of the sugar-map memory. Drop events increment the colony sugar store. This frees the ant array from memory arbitration.

---
 rtl/sugar_event_queue.sv | 162 ++++++++++++++++
 tb/tb_sugar_event_queue.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sugar_event_queue.sv
// Sugar event collector: latches per-ant collect/drop events, serializes them
// through a FIFO and retires collects as sugar-map decrements, drops as colony increments.
module sugar_event_queue #(
  parameter int N_ANTS = 8,
  parameter int XW     = 8,
  parameter int YW     = 7,
  parameter int DEPTH  = 16,
  parameter int SW     = 8,
  parameter int CW     = 16
) (
  input  logic                 game_clk,
  input  logic                 RESET,
  input  logic                 capture,
  input  logic [N_ANTS-1:0]    collecting_sugar,
  input  logic [N_ANTS-1:0]    dropping_sugar,
  input  logic [N_ANTS*XW-1:0] ant_X,
  input  logic [N_ANTS*YW-1:0] ant_Y,
  output logic [XW+YW-1:0]     mem_addr,
  output logic                 mem_rd,
  input  logic [SW-1:0]        mem_rdata,
  output logic                 mem_wr,
  output logic [SW-1:0]        mem_wdata,
  output logic [CW-1:0]        colony_sugar,
  output logic                 empty_hit,
  output logic                 overflow,
  output logic                 busy
);

  localparam int AW = XW + YW;
  localparam int EW = AW + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int IW = (N_ANTS > 1) ? $clog2(N_ANTS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WT   = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  logic [N_ANTS-1:0] r_pend;
  logic [N_ANTS-1:0] r_type;
  logic [AW-1:0]     r_ant_addr [N_ANTS];
  logic [EW-1:0]     r_fifo [DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [PW:0]       r_cnt;
  logic [1:0]        r_state;
  logic [AW-1:0]     r_addr;
  logic [SW-1:0]     r_rdata;
  logic [CW-1:0]     r_col;
  logic              r_ovf;
  logic              r_busy;

  logic              w_scan_hit;
  logic [IW-1:0]     w_scan_idx;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [EW-1:0]     w_head;
  logic [N_ANTS-1:0] w_cap;
  logic [N_ANTS-1:0] w_new;
  logic [N_ANTS-1:0] w_clr;
  logic              w_lost;
  logic              w_zero;

  // Descending walk so the lowest pending index wins.
  always_comb begin
    w_scan_hit = 1'b0;
    w_scan_idx = '0;
    for (int i = N_ANTS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_scan_hit = 1'b1;
        w_scan_idx = IW'(i);
      end
    end
  end

  assign w_full = (r_cnt == (PW+1)'(DEPTH));
  assign w_push = w_scan_hit & ~w_full;
  assign w_pop  = (r_state == S_IDLE) & (r_cnt != '0);
  assign w_head = r_fifo[r_rp];
  assign w_cap  = capture ? (collecting_sugar | dropping_sugar) : '0;
  assign w_new  = w_cap & ~r_pend;
  assign w_lost = |(w_cap & r_pend);
  assign w_clr  = w_push ? (N_ANTS'(1) << w_scan_idx) : '0;

  always_ff @(posedge game_clk or posedge RESET) begin
    if (RESET) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_new;
      if (w_lost) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge game_clk) begin
    for (int i = 0; i < N_ANTS; i++) begin
      if (w_new[i]) begin
        r_type[i]     <= collecting_sugar[i];
        r_ant_addr[i] <= {ant_Y[i*YW +: YW], ant_X[i*XW +: XW]};
      end
    end
    if (w_push) r_fifo[r_wp] <= {r_type[w_scan_idx], r_ant_addr[w_scan_idx]};
  end

  always_ff @(posedge game_clk or posedge RESET) begin
    if (RESET) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge game_clk or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rdata <= '0;
      r_col   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_head[AW]) begin
              r_addr  <= w_head[AW-1:0];
              r_state <= S_RD;
            end else if (r_col != '1) begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_RD: r_state <= S_WT;
        S_WT: begin
          r_rdata <= mem_rdata;
          r_state <= S_WR;
        end
        S_WR: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge game_clk or posedge RESET) begin
    if (RESET) r_busy <= 1'b0;
    else       r_busy <= (|r_pend) | (r_cnt != '0) | (r_state != S_IDLE);
  end

  assign w_zero       = (r_rdata == '0);
  assign mem_addr     = r_addr;
  assign mem_rd       = (r_state == S_RD);
  assign mem_wr       = (r_state == S_WR);
  assign mem_wdata    = (mem_wr && !w_zero) ? r_rdata - 1'b1 : '0;
  assign empty_hit    = mem_wr & w_zero;
  assign colony_sugar = r_col;
  assign overflow     = r_ovf;
  assign busy         = r_busy;

endmodule

// File: tb/tb_sugar_event_queue.sv
// Bench for sugar_event_queue: queue-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_sugar_event_queue;

  localparam int N  = 8;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int DP = 4;
  localparam int SW = 8;
  localparam int CW = 4;
  localparam int AW = XW + YW;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            RESET = 1'b1;
  logic            capture = 1'b0;
  logic [N-1:0]    coll = '0;
  logic [N-1:0]    drop = '0;
  logic [N*XW-1:0] ax = '0;
  logic [N*YW-1:0] ay = '0;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd;
  logic [SW-1:0]   mem_rdata = 8'hA5;
  logic            mem_wr;
  logic [SW-1:0]   mem_wdata;
  logic [CW-1:0]   colony;
  logic            hit;
  logic            ovf;
  logic            busy;

  sugar_event_queue #(
    .N_ANTS(N), .XW(XW), .YW(YW), .DEPTH(DP), .SW(SW), .CW(CW)
  ) dut (
    .game_clk(clk), .RESET(RESET), .capture(capture),
    .collecting_sugar(coll), .dropping_sugar(drop),
    .ant_X(ax), .ant_Y(ay),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .colony_sugar(colony), .empty_hit(hit),
    .overflow(ovf), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] env_mem [int];
  logic [SW-1:0] mmem [int];
  int wlog [$];
  int hit_cnt = 0;

  // reference model state
  bit mp [N];
  bit mt [N];
  int ma [N];
  int mq [$];
  int m_phase = 0;
  int m_addr = 0;
  int m_rdata = 0;
  int m_col = 0;
  bit m_ovf = 0;
  bit m_busy = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dec(int v);
    return (v == 0) ? 0 : v - 1;
  endfunction

  function automatic int mrd(int a);
    return mmem.exists(a) ? int'(mmem[a]) : 0;
  endfunction

  function automatic logic [SW-1:0] erd(int a);
    return env_mem.exists(a) ? env_mem[a] : '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mp[i] = 0;
    mq.delete();
    m_phase = 0;
    m_addr = 0;
    m_col = 0;
    m_ovf = 0;
    m_busy = 0;
  endtask

  task automatic model_step();
    bit any = 0;
    int sz = mq.size();
    int sidx = -1;
    for (int i = N - 1; i >= 0; i--) if (mp[i]) begin any = 1; sidx = i; end
    m_busy = any || sz != 0 || m_phase != 0;
    if (sz >= DP) sidx = -1;
    case (m_phase)
      0: if (sz != 0) begin
        int e = mq.pop_front();
        if ((e >> AW) != 0) begin
          m_addr = e & ((1 << AW) - 1);
          m_phase = 1;
        end else if (m_col < CMAX) m_col++;
      end
      1: m_phase = 2;
      2: begin m_rdata = mrd(m_addr); m_phase = 3; end
      default: begin mmem[m_addr] = SW'(dec(m_rdata)); m_phase = 0; end
    endcase
    if (sidx >= 0) mq.push_back((int'(mt[sidx]) << AW) | ma[sidx]);
    for (int i = 0; i < N; i++) begin
      if (capture && (coll[i] || drop[i])) begin
        if (mp[i]) m_ovf = 1;
        else begin
          mp[i] = 1;
          mt[i] = coll[i];
          ma[i] = (int'(ay[i*YW +: YW]) << XW) | int'(ax[i*XW +: XW]);
        end
      end
    end
    if (sidx >= 0) mp[sidx] = 0;
  endtask

  task automatic model_proc();
    forever begin
      @(posedge clk or posedge RESET);
      if (RESET) model_reset();
      else model_step();
    end
  endtask

  task automatic monitor();
    bit rd_pend;
    int rd_a;
    forever begin
      @(negedge clk);
      chk("mem_rd", int'(mem_rd), int'(m_phase == 1));
      chk("mem_wr", int'(mem_wr), int'(m_phase == 3));
      if (m_phase == 1 || m_phase == 3) chk("mem_addr", int'(mem_addr), m_addr);
      chk("mem_wdata", int'(mem_wdata), (m_phase == 3) ? dec(m_rdata) : 0);
      chk("empty_hit", int'(hit), int'(m_phase == 3 && m_rdata == 0));
      chk("colony", int'(colony), m_col);
      chk("overflow", int'(ovf), int'(m_ovf));
      chk("busy", int'(busy), int'(m_busy));
      rd_pend = mem_rd;
      rd_a = int'(mem_addr);
      if (mem_wr) begin
        env_mem[int'(mem_addr)] = mem_wdata;
        wlog.push_back(int'(mem_wdata));
      end
      if (hit) hit_cnt++;
      @(posedge clk);
      #1;
      mem_rdata = rd_pend ? erd(rd_a) : 8'hA5;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ant(int i, int x, int y);
    ax[i*XW +: XW] = XW'(x);
    ay[i*YW +: YW] = YW'(y);
  endtask

  task automatic set_cell(int a, int v);
    env_mem[a] = SW'(v);
    mmem[a] = SW'(v);
  endtask

  task automatic do_cap(input logic [N-1:0] c, input logic [N-1:0] d);
    coll = c;
    drop = d;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    coll = '0;
    drop = '0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    tick();
    tick();
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  int exp_w4 [8] = '{2, 1, 0, 0, 0, 0, 0, 0};

  initial begin
    int n;
    int wl0;
    fork
      model_proc();
      monitor();
    join_none

    tick();
    tick();
    chk("rst_colony", int'(colony), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_ovf", int'(ovf), 0);
    RESET = 1'b0;
    tick();

    // single drop
    set_ant(0, 1, 1);
    do_cap('0, 8'h01);
    tick();
    chk("t1_colony_E1", int'(colony), 0);
    tick();
    chk("t1_colony_E2", int'(colony), 1);
    chk("t1_no_rd", int'(mem_rd), 0);
    tick();
    chk("t1_busy_E3", int'(busy), 0);

    // single collect
    set_cell(16'h205, 7);
    set_ant(3, 5, 2);
    do_cap(8'h08, '0);
    tick();
    tick();
    chk("t2_rd_E2", int'(mem_rd), 1);
    chk("t2_addr_E2", int'(mem_addr), 'h205);
    tick();
    chk("t2_rd_E3", int'(mem_rd), 0);
    tick();
    chk("t2_wr_E4", int'(mem_wr), 1);
    chk("t2_wdata_E4", int'(mem_wdata), 6);
    tick();
    chk("t2_wr_E5", int'(mem_wr), 0);
    wait_idle(40);

    // empty cell
    set_cell(16'h101, 0);
    set_ant(2, 1, 1);
    do_cap(8'h04, '0);
    tick();
    tick();
    tick();
    tick();
    chk("t3_hit_E4", int'(hit), 1);
    chk("t3_wdata_E4", int'(mem_wdata), 0);
    tick();
    chk("t3_hit_E5", int'(hit), 0);
    wait_idle(40);

    // all ants collect on one cell; FIFO (depth 4) fills and stalls scanner
    set_cell(16'h333, 3);
    for (int i = 0; i < N; i++) set_ant(i, 'h33, 3);
    wlog.delete();
    hit_cnt = 0;
    do_cap(8'hFF, '0);
    tick();
    tick();
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("t4_cycles", n, 32);
    chk("t4_nwrites", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) chk("t4_write", wlog[i], exp_w4[i]);
    chk("t4_hits", hit_cnt, 5);

    // collect+drop on one ant (collect wins), plus a plain drop
    set_cell(16'h404, 9);
    set_ant(4, 4, 4);
    wlog.delete();
    do_cap(8'h10, 8'h30);
    wait_idle(40);
    chk("t4b_colony", int'(colony), 2);
    chk("t4b_nwrites", wlog.size(), 1);
    if (wlog.size() > 0) chk("t4b_write", wlog[0], 8);

    // colony saturation (CW=4)
    do_cap('0, 8'hFF);
    wait_idle(60);
    chk("sat_colony_a", int'(colony), 10);
    do_cap('0, 8'hFF);
    wait_idle(60);
    chk("sat_colony_b", int'(colony), CMAX);

    // overflow: recapture on the scan edge
    chk("t5_ovf_before", int'(ovf), 0);
    set_cell(16'h1020, 20);
    set_ant(1, 'h20, 'h10);
    wlog.delete();
    do_cap(8'h02, '0);
    do_cap(8'h02, '0);
    chk("t5_ovf_set", int'(ovf), 1);
    wait_idle(40);
    chk("t5_nwrites", wlog.size(), 1);
    if (wlog.size() > 0) chk("t5_write", wlog[0], 19);

    // recapture of an ant stalled behind a full FIFO is lost; others retire
    for (int i = 0; i < N; i++) set_ant(i, 'h33, 3);
    wlog.delete();
    hit_cnt = 0;
    do_cap(8'hFF, '0);
    tick();
    tick();
    do_cap(8'h80, '0);
    wait_idle(100);
    chk("t5b_nwrites", wlog.size(), 8);
    chk("t5b_hits", hit_cnt, 8);
    chk("t5_ovf_sticky", int'(ovf), 1);

    // reset during WT
    set_cell(16'h205, 7);
    set_ant(3, 5, 2);
    wl0 = wlog.size();
    do_cap(8'h08, '0);
    tick();
    tick();
    tick();
    #2;
    RESET = 1'b1;
    #1;
    chk("t6_rd", int'(mem_rd), 0);
    chk("t6_wr", int'(mem_wr), 0);
    chk("t6_addr", int'(mem_addr), 0);
    chk("t6_wdata", int'(mem_wdata), 0);
    chk("t6_colony", int'(colony), 0);
    chk("t6_hit", int'(hit), 0);
    chk("t6_ovf", int'(ovf), 0);
    chk("t6_busy", int'(busy), 0);
    tick();
    RESET = 1'b0;
    tick();
    tick();
    tick();
    chk("t6_no_write", wlog.size(), wl0);
    do_cap('0, 8'h01);
    wait_idle(40);
    chk("t6_colony_after", int'(colony), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
